// File: rtl/rv32_mod_decode_stage.sv
// rv32_mod_decode_stage
// Registered decode stage: expands the pre-decoded format/func into the
// execute control bundle, buffers results in a small skid FIFO with a
// valid/ready handshake, and holds back instructions that would read a
// register still being produced by a load.
module rv32_mod_decode_stage #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_format,
    input  logic [5:0]        in_func,
    input  logic              in_is_mem_or_io,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_rf_we,
    output logic              out_op0_pc,
    output logic              out_op1_imm,
    output logic              out_ram_wr,
    output logic              out_br_is_cond,
    output logic              out_br_jmp,
    output logic [4:0]        out_alu_func,
    output logic [3:0]        out_ram_req,
    output logic [1:0]        out_wb_source,
    output logic [2:0]        out_br_cond,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
    localparam bit LAT_EN = (LOAD_LAT > 0);

    localparam logic [5:0] FMT_R = 6'b100000;
    localparam logic [5:0] FMT_I = 6'b010000;
    localparam logic [5:0] FMT_S = 6'b001000;
    localparam logic [5:0] FMT_B = 6'b001100;
    localparam logic [5:0] FMT_U = 6'b000010;
    localparam logic [5:0] FMT_J = 6'b000011;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_PC  = 2'd1;
    localparam logic [1:0] WB_LSU = 2'd2;

    typedef struct packed {
        logic              rf_we;
        logic              op0_pc;
        logic              op1_imm;
        logic              ram_wr;
        logic              br_is_cond;
        logic              br_jmp;
        logic [4:0]        alu_func;
        logic [3:0]        ram_req;
        logic [1:0]        wb_source;
        logic [2:0]        br_cond;
        logic              is_load;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } entry_t;

    entry_t            dec;
    entry_t            head;
    entry_t            mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [LW-1:0]     lat_cnt;
    logic [REG_AW-1:0] lat_rd;
    logic              use_rs1;
    logic              use_rs2;
    logic              hazard;
    logic              full;
    logic              push;
    logic              pop;
    logic [PW-1:0]     off;

    // Expand the incoming format/func into the execute control bundle and note which source registers it reads
    always_comb begin
        dec         = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        dec.pc      = in_pc;
        dec.imm     = in_imm;
        dec.rd      = in_rd;
        dec.rs1     = in_rs1;
        dec.rs2     = in_rs2;
        dec.wb_source = WB_ALU;
        case (in_format)
            FMT_R: begin
                dec.rf_we    = 1'b1;
                dec.alu_func = in_func[4:0];
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            FMT_I: begin
                dec.rf_we   = 1'b1;
                dec.op1_imm = 1'b1;
                use_rs1     = 1'b1;
                if (in_is_mem_or_io) begin
                    dec.is_load   = 1'b1;
                    dec.wb_source = WB_LSU;
                    dec.ram_req   = {1'b0, in_func[2:0]};
                end else if (in_func[5]) begin
                    dec.br_jmp    = 1'b1;
                    dec.wb_source = WB_PC;
                end else begin
                    dec.alu_func = in_func[4:0];
                end
            end
            FMT_S: begin
                dec.op1_imm = 1'b1;
                dec.ram_req = in_func[3:0];
                dec.ram_wr  = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            FMT_B: begin
                dec.br_cond    = in_func[2:0];
                dec.br_is_cond = 1'b1;
                dec.op0_pc     = 1'b1;
                dec.op1_imm    = 1'b1;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
            end
            FMT_U: begin
                dec.rf_we   = 1'b1;
                dec.op0_pc  = ~in_func[4];
                dec.op1_imm = 1'b1;
            end
            FMT_J: begin
                dec.rf_we     = 1'b1;
                dec.op0_pc    = 1'b1;
                dec.op1_imm   = 1'b1;
                dec.br_jmp    = 1'b1;
                dec.wb_source = WB_PC;
            end
            default: ;
        endcase
    end

    // Detect a read of a register that a buffered load, or a recently issued load, has yet to deliver
    always_comb begin
        hazard = 1'b0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ((CW'(off) < count) && mem[i].is_load) begin
                if ((use_rs1 && (in_rs1 != '0) && (in_rs1 == mem[i].rd)) ||
                    (use_rs2 && (in_rs2 != '0) && (in_rs2 == mem[i].rd)))
                    hazard = 1'b1;
            end
        end
        if (lat_cnt != '0) begin
            if ((use_rs1 && (in_rs1 != '0) && (in_rs1 == lat_rd)) ||
                (use_rs2 && (in_rs2 != '0) && (in_rs2 == lat_rd)))
                hazard = 1'b1;
        end
    end

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign in_ready  = ~full & ~hazard & ~flush & ~rst;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Entry storage; contents are only observable through valid slots, so no reset is needed
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= dec;
    end

    // FIFO pointers and occupancy; flush empties the buffer on the next edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Track the destination of the latest popped load for LOAD_LAT cycles after it leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
            lat_rd  <= '0;
        end else if (flush) begin
            lat_cnt <= '0;
        end else if (LAT_EN && pop && head.is_load && (head.rd != '0)) begin
            lat_cnt <= LW'(LOAD_LAT);
            lat_rd  <= head.rd;
        end else if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Present the head entry, forcing all fields to zero while the stage holds nothing
    always_comb begin
        head = out_valid ? mem[rd_ptr] : '0;
    end

    assign out_rf_we      = head.rf_we;
    assign out_op0_pc     = head.op0_pc;
    assign out_op1_imm    = head.op1_imm;
    assign out_ram_wr     = head.ram_wr;
    assign out_br_is_cond = head.br_is_cond;
    assign out_br_jmp     = head.br_jmp;
    assign out_alu_func   = head.alu_func;
    assign out_ram_req    = head.ram_req;
    assign out_wb_source  = head.wb_source;
    assign out_br_cond    = head.br_cond;
    assign out_pc         = head.pc;
    assign out_imm        = head.imm;
    assign out_rd         = head.rd;
    assign out_rs1        = head.rs1;
    assign out_rs2        = head.rs2;

endmodule

// File: tb/tb_rv32_mod_decode_stage.sv
// tb_rv32_mod_decode_stage
// Directed bench for the decode stage: a decode table sweep followed by
// hand-written sequences for backpressure, load-use stalls, flush and reset.
module tb_rv32_mod_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_format;
    logic [5:0]  in_func;
    logic        in_is_mem_or_io;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic        out_rf_we;
    logic        out_op0_pc;
    logic        out_op1_imm;
    logic        out_ram_wr;
    logic        out_br_is_cond;
    logic        out_br_jmp;
    logic [4:0]  out_alu_func;
    logic [3:0]  out_ram_req;
    logic [1:0]  out_wb_source;
    logic [2:0]  out_br_cond;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] R = 6'b100000;
    localparam logic [5:0] I = 6'b010000;
    localparam logic [5:0] S = 6'b001000;
    localparam logic [5:0] B = 6'b001100;
    localparam logic [5:0] U = 6'b000010;
    localparam logic [5:0] J = 6'b000011;
    localparam logic [5:0] F = 6'b100101;

    typedef struct {
        logic [5:0] fmt;
        logic [5:0] func;
        logic       mem;
        logic       rf_we;
        logic       op0_pc;
        logic       op1_imm;
        logic       ram_wr;
        logic       br_is_cond;
        logic       br_jmp;
        logic [4:0] alu;
        logic [3:0] ram_req;
        logic [1:0] wb;
        logic [2:0] br_cond;
        string      name;
    } vec_t;

    vec_t vecs [14];

    rv32_mod_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_format(in_format), .in_func(in_func), .in_is_mem_or_io(in_is_mem_or_io),
        .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rf_we(out_rf_we), .out_op0_pc(out_op0_pc), .out_op1_imm(out_op1_imm),
        .out_ram_wr(out_ram_wr), .out_br_is_cond(out_br_is_cond), .out_br_jmp(out_br_jmp),
        .out_alu_func(out_alu_func), .out_ram_req(out_ram_req), .out_wb_source(out_wb_source),
        .out_br_cond(out_br_cond), .out_pc(out_pc), .out_imm(out_imm),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic v, input logic [5:0] fmt, input logic [5:0] func,
                                 input logic m, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        in_valid        = v;
        in_format       = fmt;
        in_func         = func;
        in_is_mem_or_io = m;
        in_pc           = pc;
        in_imm          = imm;
        in_rd           = rd;
        in_rs1          = rs1;
        in_rs2          = rs2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushR(input logic [31:0] pc, input logic [4:0] rd);
        applyStimulus(1'b1, R, 6'b000001, 1'b0, pc, 32'h0, rd, 5'd0, 5'd0);
    endtask

    initial begin
        vecs[0]  = '{R, F,          1'b0, 1, 0, 0, 0, 0, 0, 5'b00101, 4'b0000, 2'd0, 3'b000, "dec_R"};
        vecs[1]  = '{R, 6'b011010,  1'b0, 1, 0, 0, 0, 0, 0, 5'b11010, 4'b0000, 2'd0, 3'b000, "dec_R_alt"};
        vecs[2]  = '{I, F,          1'b1, 1, 0, 1, 0, 0, 0, 5'b00000, 4'b0101, 2'd2, 3'b000, "dec_I_load"};
        vecs[3]  = '{I, F,          1'b0, 1, 0, 1, 0, 0, 1, 5'b00000, 4'b0000, 2'd1, 3'b000, "dec_I_jalr"};
        vecs[4]  = '{I, 6'b000101,  1'b0, 1, 0, 1, 0, 0, 0, 5'b00101, 4'b0000, 2'd0, 3'b000, "dec_I_alu"};
        vecs[5]  = '{I, 6'b100010,  1'b1, 1, 0, 1, 0, 0, 0, 5'b00000, 4'b0010, 2'd2, 3'b000, "dec_I_load2"};
        vecs[6]  = '{S, F,          1'b0, 0, 0, 1, 1, 0, 0, 5'b00000, 4'b0101, 2'd0, 3'b000, "dec_S"};
        vecs[7]  = '{S, F,          1'b1, 0, 0, 1, 1, 0, 0, 5'b00000, 4'b0101, 2'd0, 3'b000, "dec_S_mem"};
        vecs[8]  = '{B, F,          1'b0, 0, 1, 1, 0, 1, 0, 5'b00000, 4'b0000, 2'd0, 3'b101, "dec_B"};
        vecs[9]  = '{U, F,          1'b0, 1, 1, 1, 0, 0, 0, 5'b00000, 4'b0000, 2'd0, 3'b000, "dec_U_auipc"};
        vecs[10] = '{U, 6'b010000,  1'b0, 1, 0, 1, 0, 0, 0, 5'b00000, 4'b0000, 2'd0, 3'b000, "dec_U_lui"};
        vecs[11] = '{J, F,          1'b0, 1, 1, 1, 0, 0, 1, 5'b00000, 4'b0000, 2'd1, 3'b000, "dec_J"};
        vecs[12] = '{6'b111111, F,  1'b1, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 2'd0, 3'b000, "dec_unknown"};
        vecs[13] = '{6'b000000, F,  1'b0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 2'd0, 3'b000, "dec_zero_fmt"};

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("reset_out_pc", out_pc, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Decode sweep: one entry at a time, popped as soon as it shows up
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            applyStimulus(1'b1, vecs[i].fmt, vecs[i].func, vecs[i].mem, 32'h1000 + 32'(i * 4),
                          32'hA0 + 32'(i), 5'(i + 1), 5'd0, 5'd0);
            @(negedge clk);
            checkOutput({vecs[i].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            checkOutput({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
            checkOutput({vecs[i].name, "_ctrl"},
                {12'd0, out_rf_we, out_op0_pc, out_op1_imm, out_ram_wr, out_br_is_cond, out_br_jmp,
                 out_alu_func, out_ram_req, out_wb_source, out_br_cond},
                {12'd0, vecs[i].rf_we, vecs[i].op0_pc, vecs[i].op1_imm, vecs[i].ram_wr,
                 vecs[i].br_is_cond, vecs[i].br_jmp, vecs[i].alu, vecs[i].ram_req,
                 vecs[i].wb, vecs[i].br_cond});
            checkOutput({vecs[i].name, "_pc"}, out_pc, 32'h1000 + 32'(i * 4));
            checkOutput({vecs[i].name, "_imm"}, out_imm, 32'hA0 + 32'(i));
            checkOutput({vecs[i].name, "_rd"}, {27'd0, out_rd}, 32'(i + 1));
        end
        tick();

        // Backpressure: three entries into a two-deep buffer
        out_ready = 1'b0;
        pushR(32'h200, 5'd1);
        @(negedge clk);
        checkOutput("bp_ready_a", {31'd0, in_ready}, 32'd1);
        tick();
        pushR(32'h204, 5'd2);
        @(negedge clk);
        checkOutput("bp_ready_b", {31'd0, in_ready}, 32'd1);
        tick();
        pushR(32'h208, 5'd3);
        @(negedge clk);
        checkOutput("bp_full_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_head_a", out_pc, 32'h200);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_still_full", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_head_a_hold", out_pc, 32'h200);
        tick();
        @(negedge clk);
        checkOutput("bp_head_b", out_pc, 32'h204);
        checkOutput("bp_ready_c", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_head_c", out_pc, 32'h208);
        checkOutput("bp_head_c_rd", {27'd0, out_rd}, 32'd3);
        tick();
        @(negedge clk);
        checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);

        // Load-use: add reading rd=5 right after the load leaves
        tick();
        applyStimulus(1'b1, I, 6'b000010, 1'b1, 32'h300, 32'h0, 5'd5, 5'd0, 5'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lu_load_rd", {27'd0, out_rd}, 32'd5);
        tick();
        applyStimulus(1'b1, R, 6'b000000, 1'b0, 32'h304, 32'h0, 5'd6, 5'd5, 5'd0);
        @(negedge clk);
        checkOutput("lu_stall", {31'd0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("lu_release", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lu_add_out", out_pc, 32'h304);
        tick();

        // Load with rd=0 never stalls, not even a reader of x0
        applyStimulus(1'b1, I, 6'b000010, 1'b1, 32'h310, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, R, 6'b000000, 1'b0, 32'h314, 32'h0, 5'd6, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lu0_buffered_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lu0_add_out", out_pc, 32'h314);
        tick();

        // Store waiting on a load still sitting in the buffer
        out_ready = 1'b0;
        applyStimulus(1'b1, I, 6'b000010, 1'b1, 32'h400, 32'h0, 5'd7, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, S, 6'b000010, 1'b0, 32'h404, 32'h0, 5'd0, 5'd0, 5'd7);
        @(negedge clk);
        checkOutput("bh_buffered", {31'd0, in_ready}, 32'd0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bh_buffered2", {31'd0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("bh_latency", {31'd0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("bh_release", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bh_store_wr", {31'd0, out_ram_wr}, 32'd1);
        checkOutput("bh_store_rs2", {27'd0, out_rs2}, 32'd7);
        tick();

        // Flush with a full buffer and an entry on offer
        out_ready = 1'b0;
        pushR(32'h500, 5'd1);
        tick();
        pushR(32'h504, 5'd2);
        tick();
        pushR(32'h508, 5'd3);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("fl_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("fl_empty", {31'd0, out_valid}, 32'd0);
        checkOutput("fl_ready_after", {31'd0, in_ready}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("fl_no_ghost", {31'd0, out_valid}, 32'd0);
        pushR(32'h50C, 5'd4);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("fl_refill", out_pc, 32'h50C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-stream with two buffered entries
        pushR(32'h600, 5'd1);
        tick();
        pushR(32'h604, 5'd2);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rs_pre_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rs_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rs_pc", out_pc, 32'd0);
        checkOutput("rs_rd", {27'd0, out_rd}, 32'd0);
        checkOutput("rs_rf_we", {31'd0, out_rf_we}, 32'd0);
        checkOutput("rs_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        pushR(32'h700, 5'd9);
        @(negedge clk);
        checkOutput("rs_accept_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rs_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rs_first_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("rs_first_pc", out_pc, 32'h700);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
